// File: rtl/serial_deserializer_pkg.sv
// Shared types and constants for the serial deserializer.
// Frame length grows by one parity bit when SERIAL_DESERIALIZER_PARITY_EN is defined.
package serial_deserializer_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STALL = 2'd2
   } state_t;

   function automatic int unsigned frame_bits(input int unsigned width);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/serial_deserializer_shift_reg.sv
// LSB-first shift register with frame bit counter; sin enters at the MSB.
// sr_next exposes the value after the current shift so a completing frame can be captured on the same edge.
module deser_shift_reg #(
   parameter int unsigned FRAME = 8,
   parameter int unsigned CW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             shift,
   input  logic             restart,
   input  logic             sin,
   output logic [FRAME-1:0] sr,
   output logic [FRAME-1:0] sr_next,
   output logic [CW-1:0]    cnt
);

   always_comb begin
      sr_next = {sin, sr[FRAME-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr  <= '0;
         cnt <= '0;
      end else if (clr) begin
         sr  <= '0;
         cnt <= '0;
      end else if (shift) begin
         sr  <= sr_next;
         cnt <= restart ? '0 : cnt + 1'b1;
      end else if (restart) begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer with one-word output register and stall on backpressure.
// Optional even-parity frame bit and parity_err output via SERIAL_DESERIALIZER_PARITY_EN.
module serial_deserializer
   import serial_deserializer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sin,
   input  logic                       sin_en,
   input  logic                       clr,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic [$clog2(WIDTH+2)-1:0] bit_cnt,
`ifdef SERIAL_DESERIALIZER_PARITY_EN
   output logic                       parity_err,
`endif
   output logic                       overrun
);

   localparam int unsigned FRAME = frame_bits(WIDTH);
   localparam int unsigned CW    = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

   state_t           state, state_nx;
   logic [FRAME-1:0] sr, sr_next;
   logic             last_bit, can_load;
   logic             shift, restart, load_new, rel_held, drop;

   assign last_bit = (bit_cnt == LAST);
   assign can_load = !dout_valid || dout_ready;

   deser_shift_reg #(
      .FRAME (FRAME),
      .CW    (CW)
   ) u_shift (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .shift   (shift),
      .restart (restart),
      .sin     (sin),
      .sr      (sr),
      .sr_next (sr_next),
      .cnt     (bit_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (clr) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE, SHIFT: begin
               if (sin_en) begin
                  if (!last_bit)     state_nx = SHIFT;
                  else if (can_load) state_nx = IDLE;
                  else               state_nx = STALL;
               end
            end
            STALL: if (dout_valid && dout_ready) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // A completing frame is captured straight from sr_next, so no bit waits an extra cycle.
   always_comb begin
      shift    = 1'b0;
      load_new = 1'b0;
      rel_held = 1'b0;
      drop     = 1'b0;
      if (!clr) begin
         if (state == STALL) begin
            drop     = sin_en;
            rel_held = dout_valid && dout_ready;
         end else begin
            shift    = sin_en;
            load_new = sin_en && last_bit && can_load;
         end
      end
      restart = load_new || rel_held;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else if (load_new) begin
         dout       <= sr_next[WIDTH-1:0];
         dout_valid <= 1'b1;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
         parity_err <= ^sr_next;
`endif
      end else if (rel_held) begin
         dout       <= sr[WIDTH-1:0];
         dout_valid <= 1'b1;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
         parity_err <= ^sr;
`endif
      end else if (dout_valid && dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    overrun <= 1'b0;
      else if (clr)  overrun <= 1'b0;
      else if (drop) overrun <= 1'b1;
   end

endmodule

// File: tb/tb_serial_deserializer.sv
// Randomized and directed bench for serial_deserializer against a queue-based frame model.
// Parity checks are compiled in when SERIAL_DESERIALIZER_PARITY_EN is defined.
module tb_serial_deserializer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CW    = $clog2(WIDTH + 2);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
   localparam int unsigned FRAME = WIDTH + 1;
`else
   localparam int unsigned FRAME = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             sin = 1'b0;
   logic             sin_en = 1'b0;
   logic             clr = 1'b0;
   logic             dout_ready = 1'b0;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic [CW-1:0]    bit_cnt;
   logic             overrun;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
   logic             parity_err;
`endif

   serial_deserializer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sin        (sin),
      .sin_en     (sin_en),
      .clr        (clr),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .bit_cnt    (bit_cnt),
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      .parity_err (parity_err),
`endif
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: collected frame bits in arrival order plus the output register.
   bit               mq[$];
   logic [WIDTH-1:0] m_dout;
   bit               m_valid, m_ovr, m_perr;

   task automatic model_reset();
      mq.delete();
      m_dout = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
   endtask

   task automatic deliver();
      m_perr = 0;
      for (int i = 0; i < int'(FRAME); i++) begin
         if (i < int'(WIDTH)) m_dout[i] = mq[i];
         m_perr = m_perr ^ mq[i];
      end
      m_valid = 1;
      mq.delete();
   endtask

   task automatic model_edge(input bit en, input bit s, input bit c, input bit r);
      bit old_valid;
      bit hs;
      old_valid = m_valid;
      hs = old_valid && r;
      if (hs) m_valid = 0;
      if (c) begin
         mq.delete();
         m_ovr = 0;
      end else if (mq.size() == FRAME) begin
         if (en) m_ovr = 1;
         if (hs) deliver();
      end else if (en) begin
         mq.push_back(s);
         if (mq.size() == FRAME && (!old_valid || r)) deliver();
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".dout"},    32'(dout),       32'(m_dout));
      check({tag, ".valid"},   32'(dout_valid), 32'(m_valid));
      check({tag, ".bit_cnt"}, 32'(bit_cnt),    32'(mq.size()));
      check({tag, ".overrun"}, 32'(overrun),    32'(m_ovr));
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      if (m_valid) check({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
`endif
   endtask

   task automatic step(input bit en, input bit s, input bit c, input bit r, input string tag);
      sin_en = en; sin = s; clr = c; dout_ready = r;
      @(posedge clk);
      model_edge(en, s, c, r);
      #1;
      check_all(tag);
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input bit gaps, input bit r, input string tag);
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (gaps) begin
            int unsigned g;
            g = $urandom_range(3, 1);
            for (int k = 0; k < int'(g); k++) step(0, 1'b1, 0, r, {tag, ".gap"});
         end
         step(1, w[i], 0, r, tag);
      end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      step(1, ^w, 0, r, {tag, ".par"});
`endif
   endtask

   initial begin
      model_reset();
      #2;
      check("reset.dout",    32'(dout),       32'h0);
      check("reset.valid",   32'(dout_valid), 32'h0);
      check("reset.bit_cnt", 32'(bit_cnt),    32'h0);
      check("reset.overrun", 32'(overrun),    32'h0);
      rst_n = 1'b1;

      // Contiguous 0xA5 with ready held high.
      send_word(8'hA5, 0, 1, "a5");
      check("a5.word",  32'(dout),       32'hA5);
      check("a5.valid", 32'(dout_valid), 32'h1);
      check("a5.cnt",   32'(bit_cnt),    32'h0);

      // Same word with idle gaps between bits.
      step(0, 0, 0, 1, "drain");
      send_word(8'hA5, 1, 1, "a5gap");
      check("a5gap.word", 32'(dout), 32'hA5);

      // Backpressure: 0x3C lands, 0xC3 stalls, extra bit overruns.
      step(0, 0, 0, 1, "drain");
      send_word(8'h3C, 0, 0, "w3c");
      check("w3c.word", 32'(dout), 32'h3C);
      send_word(8'hC3, 0, 0, "wc3");
      check("stall.dout", 32'(dout),    32'h3C);
      check("stall.cnt",  32'(bit_cnt), 32'(FRAME));
      step(1, 1, 0, 0, "extra");
      check("stall.overrun", 32'(overrun), 32'h1);
      check("stall.cnt2",    32'(bit_cnt), 32'(FRAME));
      step(0, 0, 0, 1, "release");
      check("release.dout",  32'(dout),       32'hC3);
      check("release.valid", 32'(dout_valid), 32'h1);
      check("release.cnt",   32'(bit_cnt),    32'h0);
      step(0, 0, 0, 1, "drain");
      step(0, 0, 1, 0, "clr_ovr");
      check("clr.overrun", 32'(overrun), 32'h0);

      // Abort partial word with clr, then eight ones.
      for (int i = 0; i < 5; i++) step(1, 1'($urandom), 0, 1, "part");
      step(1, 1, 1, 1, "clr");
      check("clr.cnt", 32'(bit_cnt), 32'h0);
      send_word(8'hFF, 0, 1, "ff");
      check("ff.word", 32'(dout), 32'hFF);

      // Asynchronous reset mid-frame at bit_cnt=4.
      for (int i = 0; i < 4; i++) step(1, 1'($urandom), 0, 1, "pre_rst");
      check("pre_rst.cnt", 32'(bit_cnt), 32'h4);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check("arst.dout",    32'(dout),       32'h0);
      check("arst.valid",   32'(dout_valid), 32'h0);
      check("arst.cnt",     32'(bit_cnt),    32'h0);
      check("arst.overrun", 32'(overrun),    32'h0);
      #2 rst_n = 1'b1;
      send_word(8'h5A, 0, 1, "w5a");
      check("w5a.word", 32'(dout), 32'h5A);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
      step(0, 0, 0, 1, "drain");
      for (int i = 0; i < 8; i++) step(1, (i < 3), 0, 1, "p07a");
      step(1, 0, 0, 1, "p07a.par");
      check("p07_bad.word", 32'(dout),       32'h07);
      check("p07_bad.perr", 32'(parity_err), 32'h1);
      for (int i = 0; i < 8; i++) step(1, (i < 3), 0, 1, "p07b");
      step(1, 1, 0, 1, "p07b.par");
      check("p07_good.perr", 32'(parity_err), 32'h0);
`endif

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         step(($urandom % 10) < 7, 1'($urandom), ($urandom % 50) == 0,
              1'($urandom), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
